// File: rtl/dict_arb_pkg.sv
// Shared types and default widths for the dictionary ROM arbiter.
package dict_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    ARB      = 1'b0,
    LOCK_ENG = 1'b1
  } state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_ENG = 1'b1
  } owner_e;

endpackage

// File: rtl/dict_arb_rr2.sv
// Two-way round-robin pick: bit 0 = CPU, bit 1 = engine; a tie goes to
// whichever requester did not own the ROM last.
module dict_arb_rr2
  import dict_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_e     i_last_owner,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_last_owner == OWNER_ENG) ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

endmodule

// File: rtl/dict_mem_arbiter.sv
// Arbitrates the single-port dictionary ROM between CPU and engine, with a
// bounded engine lock. Optional grant/stall counters via DICT_ARB_STATS_EN.
module dict_mem_arbiter
  import dict_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              eng_req,
  input  logic              eng_lock,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
`ifdef DICT_ARB_STATS_EN
  ,
  output logic [31:0]       cpu_grant_cnt,
  output logic [31:0]       eng_grant_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);
  // With LOCK_MAX == 1 the first locked grant is also the last one.
  localparam bit         LOCK_EN    = (LOCK_MAX > 1);

  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            r_last_owner;
  logic [7:0]        r_lock_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_cpu_rvalid;
  logic              r_eng_rvalid;
  logic [1:0]        w_rr_gnt;
  logic              w_cpu_gnt;
  logic              w_eng_gnt;
  logic              w_lock_done;
  logic              w_lock_start;

  dict_arb_rr2 u_rr2 (
    .i_req        ({eng_req, cpu_req}),
    .i_last_owner (r_last_owner),
    .o_gnt        (w_rr_gnt)
  );

  assign w_lock_done  = (r_lock_cnt + 8'd1) >= LOCK_MAX_C;
  assign w_lock_start = w_eng_gnt && eng_lock && LOCK_EN;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB: begin
        if (w_lock_start) w_state_nxt = LOCK_ENG;
      end
      LOCK_ENG: begin
        // Forced release wins over a still-asserted eng_lock.
        if ((w_eng_gnt && !eng_lock) || w_lock_done) w_state_nxt = ARB;
      end
    endcase
  end

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_eng_gnt = 1'b0;
    if (reset) begin
      case (r_state)
        ARB:      {w_eng_gnt, w_cpu_gnt} = w_rr_gnt;
        LOCK_ENG: w_eng_gnt = eng_req;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lock_cnt <= '0;
    end else if (r_state == ARB) begin
      r_lock_cnt <= w_lock_start ? 8'd1 : 8'd0;
    end else begin
      r_lock_cnt <= w_lock_done ? LOCK_MAX_C : r_lock_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last_owner <= OWNER_ENG;
      r_addr       <= '0;
      r_cpu_rvalid <= 1'b0;
      r_eng_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt;
      r_eng_rvalid <= w_eng_gnt;
      if (w_cpu_gnt) begin
        r_last_owner <= OWNER_CPU;
        r_addr       <= cpu_addr;
      end else if (w_eng_gnt) begin
        r_last_owner <= OWNER_ENG;
        r_addr       <= eng_addr;
      end
    end
  end

  assign cpu_gnt  = w_cpu_gnt;
  assign eng_gnt  = w_eng_gnt;
  assign rom_addr = w_cpu_gnt ? cpu_addr : (w_eng_gnt ? eng_addr : r_addr);

  // Gating with reset drops a response still in flight when reset arrives.
  assign cpu_rvalid = r_cpu_rvalid && reset;
  assign eng_rvalid = r_eng_rvalid && reset;
  assign cpu_rdata  = cpu_rvalid ? rom_data : '0;
  assign eng_rdata  = eng_rvalid ? rom_data : '0;

`ifdef DICT_ARB_STATS_EN
  logic [31:0] r_cpu_grant_cnt;
  logic [31:0] r_eng_grant_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (cpu_req && !w_cpu_gnt) || (eng_req && !w_eng_gnt);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cpu_grant_cnt <= '0;
      r_eng_grant_cnt <= '0;
      r_stall_cnt     <= '0;
    end else begin
      if (w_cpu_gnt && (r_cpu_grant_cnt != '1)) r_cpu_grant_cnt <= r_cpu_grant_cnt + 32'd1;
      if (w_eng_gnt && (r_eng_grant_cnt != '1)) r_eng_grant_cnt <= r_eng_grant_cnt + 32'd1;
      if (w_stall && (r_stall_cnt != '1))       r_stall_cnt     <= r_stall_cnt + 32'd1;
    end
  end

  assign cpu_grant_cnt = r_cpu_grant_cnt;
  assign eng_grant_cnt = r_eng_grant_cnt;
  assign stall_cnt     = r_stall_cnt;
`endif

endmodule

// File: doc/dict_mem_arbiter.md
Name: dict_mem_arbiter

Overview:
- Shares the single-port dictionary ROM (12-bit address, 32-bit word, registered read) between the CPU and the hardware decrypt/search engine.
- Sits between both requesters and the DictMem ROM instance in the top-level wrapper.
- Provides round-robin arbitration, a bounded lock for sequential engine bursts, and a one-read-per-cycle pipelined response path.

Parameters:
- ADDR_W, 12, dictionary word-address width.
- DATA_W, 32, dictionary word width.
- LOCK_MAX, 16, maximum consecutive locked grants before a forced release (range 1..255).

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU read request for this cycle.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_gnt  out  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  out  1  cpu_rdata valid (registered).
- cpu_rdata  out  DATA_W  read data to CPU.
- eng_req  in  1  engine read request.
- eng_lock  in  1  engine requests to keep ownership after this grant.
- eng_addr  in  ADDR_W  engine word address.
- eng_gnt  out  1  engine request accepted (combinational).
- eng_rvalid  out  1  eng_rdata valid (registered).
- eng_rdata  out  DATA_W  read data to engine.
- rom_addr  out  ADDR_W  address to dictionary ROM.
- rom_data  in  DATA_W  ROM output, valid one cycle after the address is sampled.

Behaviour:
- Reset (reset==0 at posedge):
  - state=ARB, last_owner=ENG (CPU wins the first tie), lock_cnt=0, rom_addr register=0.
  - cpu_rvalid=eng_rvalid=0.
  - An in-flight response is discarded; no rvalid is produced for it.
- Handshake:
  - A request is accepted in the cycle where req && gnt; the requester may change its address the following cycle.
  - Holding req without gnt is legal; the address must stay stable until granted.
  - At most one gnt is high per cycle.
- Latency:
  - Grant in cycle N gives rvalid in cycle N+1 for the same requester, with rdata=rom_data.
  - rdata is forced to 0 when rvalid=0.
  - Throughput is one read per cycle.
- rom_addr:
  - Equals the winner's address in a grant cycle.
  - Otherwise holds the last granted address (register updated on grant).
- FSM:
  - ARB:
    - Only one requester active: grant it.
    - Both active: grant the one that is not last_owner; update last_owner.
    - If eng is granted with eng_lock=1: go to LOCK_ENG, lock_cnt=1.
  - LOCK_ENG:
    - Engine has exclusive ownership; cpu_gnt=0.
    - eng_req=1: grant eng, lock_cnt++.
    - eng_req=0: no grant; ownership is kept and the cycle still counts toward lock_cnt.
    - Exit to ARB when eng_lock=0 on a granted cycle (that grant is the last locked one).
    - Exit to ARB when lock_cnt reaches LOCK_MAX. If cpu_req is high at that point, the next ARB cycle must grant the CPU (last_owner=ENG).
  - The CPU has no lock capability.
- Simultaneous events:
  - Forced release and eng_lock=1 in the same cycle: release wins. The engine must re-arbitrate and may re-lock after the CPU is served.
- Boundaries:
  - LOCK_MAX=1 behaves as plain round-robin.
  - lock_cnt never wraps; it saturates at LOCK_MAX.
  - Address 0 and 2^ADDR_W-1 are passed unmodified; there is no address translation.

Optional Feature:
- Macro: DICT_ARB_STATS_EN.
- When defined, adds the following outputs, all cleared on reset:
  - cpu_grant_cnt (32): saturating count of CPU grants.
  - eng_grant_cnt (32): saturating count of engine grants.
  - stall_cnt (32): saturating count of cycles where any req is high without its gnt.
- When undefined, these ports and counters do not exist; arbitration behaviour is identical either way.

Decomposition:
- Package dict_arb_pkg:
  - state encoding (ARB, LOCK_ENG);
  - owner encoding (OWNER_CPU, OWNER_ENG);
  - default ADDR_W/DATA_W constants.
- One natural sub-module: dict_arb_rr2, the combinational two-way round-robin pick (req pair + last_owner in, one-hot grant out).
- FSM, lock counter, response pipeline and stats stay in the top.

Test Plan:
- Reset low 2 cycles with both reqs high -> no gnt, no rvalid, rom_addr=0. After release, the first contended cycle grants the CPU.
- CPU only, addresses 0x000, 0x001, 0xFFF back-to-back -> cpu_gnt each cycle; cpu_rvalid the next cycle with matching ROM words; eng outputs stay 0.
- Both request continuously, no lock -> grants alternate CPU, ENG, CPU, ENG...; each rvalid is routed to the correct requester.
- LOCK_MAX=4, engine holds eng_req=eng_lock=1, CPU requests from cycle 0 -> 4 consecutive eng grants, then a CPU grant, then the engine re-locks.
- Engine locked, eng_lock drops on its 2nd grant with the CPU waiting -> the next cycle grants the CPU.
- Reset asserted the cycle after an eng grant -> eng_rvalid stays 0 and the state returns to ARB.
